// File: rtl/updn_cnt_sm.sv
// Parametrised up/down counter with a one-hot control FSM, parallel load and
// selectable boundary policy (sticky error, wrap or saturate).
module updn_cnt_sm #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 2,
  parameter int unsigned MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act,
  input  logic              up_dwn_n,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_err,
  output logic [WIDTH-1:0]  count,
  output logic [3:0]        state,
  output logic              ovf,
  output logic              unf,
  output logic              err,
  output logic              at_max,
  output logic              at_min
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    CNTUP = 4'b0010,
    CNTDN = 4'b0100,
    ERR   = 4'b1000
  } state_e;

  localparam logic [WIDTH-1:0] MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             count_en;

  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};

  // MSB of the WIDTH+1 result flags crossing MAX (sum) or borrowing below 0 (diff).
  always_comb begin
    state_d = IDLE;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    sum     = {1'b0, count_q} + step_ext;
    diff    = {1'b0, count_q} - step_ext;
    case (state_q)
      ERR: state_d = clr_err ? IDLE : ERR;
      IDLE, CNTUP, CNTDN: begin
        if (load) begin
          count_d = load_val;
        end else if (act) begin
          if (up_dwn_n) begin
            state_d = CNTUP;
            if (!sum[WIDTH]) begin
              count_d = sum[WIDTH-1:0];
            end else begin
              ovf_d = 1'b1;
              if (MODE == 0)      state_d = ERR;
              else if (MODE == 1) count_d = sum[WIDTH-1:0];
              else                count_d = MAX;
            end
          end else begin
            state_d = CNTDN;
            if (!diff[WIDTH]) begin
              count_d = diff[WIDTH-1:0];
            end else begin
              unf_d = 1'b1;
              if (MODE == 0)      state_d = ERR;
              else if (MODE == 1) count_d = diff[WIDTH-1:0];
              else                count_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_en = (count_d != count_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (count_en) count_q <= count_d;
  end

`ifndef SYNTHESIS
  illegal_state_a: assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {IDLE, CNTUP, CNTDN, ERR});
`endif

  assign count  = count_q;
  assign state  = state_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;
  assign err    = (state_q == ERR);
  assign at_max = (count_q == MAX);
  assign at_min = (count_q == '0);

endmodule

// File: doc/updn_cnt_sm.md
Name: updn_cnt_sm

Overview:
- Parametrised up/down counter with a control state machine.
- Generalises the fixed 4-bit sticky-overflow counter: configurable width, variable step size, parallel load, and a selectable boundary mode (sticky error, wrap or saturate).
- Error is clearable without a reset.
- Used as the sample/occupancy counter in the streaming-average datapath. The count register is enabled only on cycles where its value changes, which saves power.

Parameters:
- WIDTH, 8, counter width in bits (>=2).
- STEP_W, 2, width of the step input (1..WIDTH).
- MODE, 0, boundary policy: 0 = sticky error, 1 = wrap (modulo 2^WIDTH), 2 = saturate at 0 / MAX.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- act  in  1  count enable.
- up_dwn_n  in  1  direction: 1 = up, 0 = down; sampled only when act=1.
- step  in  STEP_W  unsigned increment/decrement amount.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value written by load.
- clr_err  in  1  exits ERR state.
- count  out  WIDTH  registered counter value.
- state  out  4  registered one-hot state: IDLE=0001, CNTUP=0010, CNTDN=0100, ERR=1000.
- ovf  out  1  registered 1-cycle pulse: an up-count crossed MAX.
- unf  out  1  registered 1-cycle pulse: a down-count crossed 0.
- err  out  1  level, equal to (state==ERR).
- at_max  out  1  combinational, count == 2^WIDTH-1.
- at_min  out  1  combinational, count == 0.

Behaviour:
- Reset (async, rst_n=0): count=0, state=IDLE, ovf=0, unf=0, err=0. Reset takes effect immediately, also mid-count or in ERR.
- Zero latency: inputs sampled at edge N update count and state at edge N; state encodes the operation just performed.
- MAX = 2^WIDTH-1. Arithmetic is done in WIDTH+1 bits with step zero-extended.
  - up: sum = count+step; overflow when sum > MAX.
  - down: overflow when step > count (underflow).
- Priority per cycle, highest first: ERR handling > load > act > idle.
- In ERR:
  - clr_err=1 gives state=IDLE with count held.
  - Otherwise the block stays in ERR with count held.
  - load and act are ignored, including when asserted together with clr_err.
- load=1 (not in ERR): count=load_val, state=IDLE, no pulses. act is ignored that cycle.
- act=1, no load, no boundary crossing: count = count±step; state = CNTUP (up) or CNTDN (down).
- act=1 with step=0: count unchanged, state = CNTUP/CNTDN, no pulses.
- act=1 with a boundary crossing, by MODE:
  - MODE 0: state=ERR, count held at its pre-crossing value, ovf/unf pulses once.
  - MODE 1: count = sum mod 2^WIDTH (down wraps likewise), state = CNTUP/CNTDN, ovf/unf pulses.
  - MODE 2: count = MAX (up) or 0 (down), state = CNTUP/CNTDN, ovf/unf pulses. In MODE 2 the pulse repeats on every cycle that attempts to go past the bound. Exception: a step that lands exactly on the bound is not a crossing and gives no pulse.
- act=0, no load, not ERR: state=IDLE, count held.
- ovf and unf are never high in the same cycle. Each is low on every cycle that does not cause a crossing.
- clr_err outside ERR has no effect.
- ERR is unreachable in MODE 1 and MODE 2; err stays 0.
- The count register is updated only when its next value differs (load, or act with a nonzero effective change).
- Illegal state encodings go to IDLE on the next edge with count held, and must be flagged in simulation.

Test Plan:
- Reset mid-operation: WIDTH=4, load 9, count up, assert rst_n=0 asynchronously between edges -> count=0, state=0001 immediately, no pulses.
- MODE 0, WIDTH=4, STEP_W=2: load 14, act=1, up, step=1 -> 15 (at_max=1, CNTUP). Next step=1 -> ERR, count=15, ovf high 1 cycle. Then act+load -> held. clr_err -> IDLE, count=15.
- MODE 1, WIDTH=4: load 1, down, step=3 -> count=14, unf pulse, state=0100. Then up, step=2 -> count=0, ovf pulse, at_min=1.
- MODE 2, WIDTH=4: load 13, up, step=2 -> 15, no pulse. Up, step=1 for 2 cycles -> count stays 15, ovf high both cycles. Down, step=3 from 2 -> 0, unf pulse.
- Priority: load=1 with load_val=5 and act=1/up/step=3 in the same cycle -> count=5, state=IDLE. Next cycle act, up, step=0 -> count=5, state=CNTUP, no pulse.
- Direction flip: alternate up/down, step=1 each cycle from 7 -> count alternates 8/7, state alternates 0010/0100, ovf=unf=0 throughout.
